// File: rtl/ctu_burst_gen_if.sv
// Burst generator bus: burst request/control inputs and transducer/status outputs.
// The slave modport is the generator's view; master is the controller's view.
interface ctu_burst_gen_if;
   logic       iSTART;
   logic       iABORT;
   logic [7:0] iPULSES;
   logic       oTX;
   logic       oTX_N;
   logic       oBUSY;
   logic       oBLANK;
   logic       oDONE;
   logic [7:0] oBURST_CNT;

   modport slave (
      input  iSTART, iABORT, iPULSES,
      output oTX, oTX_N, oBUSY, oBLANK, oDONE, oBURST_CNT
   );

   modport master (
      output iSTART, iABORT, iPULSES,
      input  oTX, oTX_N, oBUSY, oBLANK, oDONE, oBURST_CNT
   );
endinterface

// File: rtl/ctu_burst_gen.sv
// Ultrasonic transmit burst generator: drives N complementary square-wave
// pulses on the transducer legs, then gates the echo receiver for a blanking
// window, then strobes done and counts the completed burst.
// All outputs come straight from flops so the driver legs never glitch.
module ctu_burst_gen #(
   parameter int HALF_PERIOD  = 500,
   parameter int BLANK_CYCLES = 40000,
   parameter int CNT_W        = 16
) (
   input  logic             iCLK_40,
   input  logic             iRST,
   ctu_burst_gen_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      BLANK = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_PERIOD - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   state_t           state_r,     state_s;
   logic [CNT_W-1:0] half_cnt_r,  half_cnt_s;
   logic [CNT_W-1:0] blank_cnt_r, blank_cnt_s;
   logic [7:0]       pulse_cnt_r, pulse_cnt_s;
   logic [7:0]       burst_cnt_r, burst_cnt_s;
   logic             tx_r,        tx_s;
   logic             tx_n_r,      tx_n_s;
   logic             busy_r,      busy_s;
   logic             blank_r,     blank_s;
   logic             done_r,      done_s;

   // Next-state and next-output logic; tx_r doubles as the high/low half-cycle phase.
   always_comb begin
      state_s     = state_r;
      half_cnt_s  = half_cnt_r;
      blank_cnt_s = blank_cnt_r;
      pulse_cnt_s = pulse_cnt_r;
      burst_cnt_s = burst_cnt_r;
      tx_s        = tx_r;
      tx_n_s      = tx_n_r;
      busy_s      = busy_r;
      blank_s     = blank_r;
      done_s      = 1'b0;

      case (state_r)
         IDLE: begin
            tx_s    = 1'b0;
            tx_n_s  = 1'b0;
            busy_s  = 1'b0;
            blank_s = 1'b0;
            if (bus.iSTART && (bus.iPULSES != 8'd0) && !bus.iABORT) begin
               state_s     = BURST;
               pulse_cnt_s = bus.iPULSES;
               half_cnt_s  = CNT_ZERO;
               tx_s        = 1'b1;
               tx_n_s      = 1'b0;
               busy_s      = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end

         BURST: begin
            if (bus.iABORT) begin
               state_s = IDLE;
               tx_s    = 1'b0;
               tx_n_s  = 1'b0;
               busy_s  = 1'b0;
               blank_s = 1'b0;
            end else if (half_cnt_r == HALF_LAST) begin
               half_cnt_s = CNT_ZERO;
               if (tx_r) begin
                  tx_s   = 1'b0;
                  tx_n_s = 1'b1;
               end else if (pulse_cnt_r == 8'd1) begin
                  // last low half-cycle ends: driver off, receiver gate opens
                  state_s     = BLANK;
                  blank_cnt_s = CNT_ZERO;
                  tx_s        = 1'b0;
                  tx_n_s      = 1'b0;
                  blank_s     = 1'b1;
               end else begin
                  pulse_cnt_s = pulse_cnt_r - 8'd1;
                  tx_s        = 1'b1;
                  tx_n_s      = 1'b0;
               end
            end else begin
               half_cnt_s = half_cnt_r + CNT_ONE;
            end
         end

         BLANK: begin
            if (bus.iABORT) begin
               state_s = IDLE;
               busy_s  = 1'b0;
               blank_s = 1'b0;
            end else if (blank_cnt_r == BLANK_LAST) begin
               state_s     = IDLE;
               busy_s      = 1'b0;
               blank_s     = 1'b0;
               done_s      = 1'b1;
               burst_cnt_s = burst_cnt_r + 8'd1;
            end else begin
               blank_cnt_s = blank_cnt_r + CNT_ONE;
            end
         end

         default: begin
            state_s = IDLE;
            tx_s    = 1'b0;
            tx_n_s  = 1'b0;
            busy_s  = 1'b0;
            blank_s = 1'b0;
         end
      endcase
   end

   // State, counter and output registers; reset drops the driver immediately.
   always_ff @(posedge iCLK_40 or posedge iRST) begin
      if (iRST) begin
         state_r     <= IDLE;
         half_cnt_r  <= CNT_ZERO;
         blank_cnt_r <= CNT_ZERO;
         pulse_cnt_r <= 8'd0;
         burst_cnt_r <= 8'd0;
         tx_r        <= 1'b0;
         tx_n_r      <= 1'b0;
         busy_r      <= 1'b0;
         blank_r     <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         half_cnt_r  <= half_cnt_s;
         blank_cnt_r <= blank_cnt_s;
         pulse_cnt_r <= pulse_cnt_s;
         burst_cnt_r <= burst_cnt_s;
         tx_r        <= tx_s;
         tx_n_r      <= tx_n_s;
         busy_r      <= busy_s;
         blank_r     <= blank_s;
         done_r      <= done_s;
      end
   end

   assign bus.oTX        = tx_r;
   assign bus.oTX_N      = tx_n_r;
   assign bus.oBUSY      = busy_r;
   assign bus.oBLANK     = blank_r;
   assign bus.oDONE      = done_r;
   assign bus.oBURST_CNT = burst_cnt_r;

endmodule

// File: tb/tb_ctu_burst_gen.sv
// Self-checking bench for ctu_burst_gen with short timing parameters.
module tb_ctu_burst_gen;

   localparam int H = 4;
   localparam int B = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   ctu_burst_gen_if bus ();

   ctu_burst_gen #(.HALF_PERIOD(H), .BLANK_CYCLES(B), .CNT_W(16)) dut (
      .iCLK_40 (clk),
      .iRST    (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // A burst is just a count of cycles since acceptance: cycles 1..2HN drive,
   // the next B cycles blank, and the edge ending cycle 2HN+B completes.
   logic m_active;
   int   m_e;
   int   m_n;
   logic m_done;
   logic [7:0] m_cnt;

   // Model advance on each edge from the inputs the DUT sees.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_active <= 1'b0;
         m_e      <= 0;
         m_n      <= 0;
         m_done   <= 1'b0;
         m_cnt    <= 8'd0;
      end else begin
         m_done <= 1'b0;
         if (m_active) begin
            if (bus.iABORT) begin
               m_active <= 1'b0;
            end else if (m_e == 2*H*m_n + B) begin
               m_active <= 1'b0;
               m_done   <= 1'b1;
               m_cnt    <= m_cnt + 8'd1;
            end else begin
               m_e <= m_e + 1;
            end
         end else if (bus.iSTART && bus.iPULSES != 8'd0 && !bus.iABORT) begin
            m_active <= 1'b1;
            m_e      <= 1;
            m_n      <= int'(bus.iPULSES);
         end
      end
   end

   // Expected {tx, tx_n, busy, blank, done}.
   function automatic logic [4:0] exp_out(input logic act, input int e, input int n, input logic dn);
      logic tx;
      if (!act) return {4'b0000, dn};
      if (e <= 2*H*n) begin
         tx = (((e - 1) % (2*H)) < H);
         return {tx, !tx, 1'b1, 1'b0, 1'b0};
      end
      return 5'b00110;
   endfunction

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      logic [4:0] act;
      logic [4:0] expv;
      act  = {bus.oTX, bus.oTX_N, bus.oBUSY, bus.oBLANK, bus.oDONE};
      expv = exp_out(m_active, m_e, m_n, m_done);
      checks = checks + 1;
      if (act !== expv || bus.oBURST_CNT !== m_cnt || (bus.oTX & bus.oTX_N)) begin
         errors = errors + 1;
         if (errors < 30)
            $display("FAIL model t=%0t outs=%b cnt=%0d required outs=%b cnt=%0d",
                     $time, act, bus.oBURST_CNT, expv, m_cnt);
      end
   end

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string name, input int actual, input int required);
      checks = checks + 1;
      if (actual != required) begin
         errors = errors + 1;
         $display("FAIL %s actual=%0d required=%0d", name, actual, required);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((bus.oBUSY || bus.oDONE) && n < 300) begin
         tick();
         n = n + 1;
      end
      check("wait_idle_timeout", int'(bus.oBUSY), 0);
   endtask

   typedef struct {
      int pulses;
      int abort_at;   // -1 none, 0 together with start, else cycle index
      int exp_busy;
      int exp_txhi;
      int exp_done;
   } vec_t;

   vec_t tbl [6];

   initial begin
      int busy_n, txhi_n, done_n, idle_n;
      logic [7:0] cnt0;

      tbl[0] = '{3, -1, 34, 12, 1};
      tbl[1] = '{1, -1, 18,  4, 1};
      tbl[2] = '{0, -1,  0,  0, 0};
      tbl[3] = '{3, 10, 10,  6, 0};
      tbl[4] = '{2, 20, 20,  8, 0};
      tbl[5] = '{3,  0,  0,  0, 0};

      bus.iSTART  = 1'b0;
      bus.iABORT  = 1'b0;
      bus.iPULSES = 8'd0;

      // reset state
      @(negedge clk);
      @(negedge clk);
      check("rst_busy", int'(bus.oBUSY), 0);
      check("rst_cnt", int'(bus.oBURST_CNT), 0);
      rst = 1'b0;
      tick();

      // table-driven single bursts
      for (int v = 0; v < 6; v++) begin
         wait_idle();
         cnt0        = bus.oBURST_CNT;
         bus.iPULSES = 8'(tbl[v].pulses);
         bus.iSTART  = 1'b1;
         bus.iABORT  = (tbl[v].abort_at == 0);
         tick();
         bus.iSTART = 1'b0;
         bus.iABORT = 1'b0;
         busy_n = 0; txhi_n = 0; done_n = 0;
         for (int c = 1; c <= 45; c++) begin
            busy_n = busy_n + int'(bus.oBUSY);
            txhi_n = txhi_n + int'(bus.oTX);
            done_n = done_n + int'(bus.oDONE);
            bus.iABORT  = (c == tbl[v].abort_at);
            bus.iPULSES = 8'($urandom);
            tick();
         end
         bus.iABORT = 1'b0;
         check($sformatf("v%0d_busy", v), busy_n, tbl[v].exp_busy);
         check($sformatf("v%0d_txhi", v), txhi_n, tbl[v].exp_txhi);
         check($sformatf("v%0d_done", v), done_n, tbl[v].exp_done);
         check($sformatf("v%0d_cnt", v), int'(bus.oBURST_CNT), int'(8'(cnt0 + 8'(tbl[v].exp_done))));
      end

      // asynchronous reset in the middle of a burst
      wait_idle();
      bus.iPULSES = 8'd3;
      bus.iSTART  = 1'b1;
      tick();
      bus.iSTART = 1'b0;
      for (int c = 0; c < 6; c++) tick();
      check("pre_rst_busy", int'(bus.oBUSY), 1);
      #2 rst = 1'b1;
      #1;
      check("arst_outs", int'({bus.oTX, bus.oTX_N, bus.oBUSY, bus.oBLANK, bus.oDONE}), 0);
      check("arst_cnt", int'(bus.oBURST_CNT), 0);
      @(negedge clk);
      rst         = 1'b0;
      bus.iPULSES = 8'd2;
      bus.iSTART  = 1'b1;
      tick();
      bus.iSTART = 1'b0;
      check("first_start_busy", int'(bus.oBUSY), 1);
      check("first_start_tx", int'(bus.oTX), 1);
      wait_idle();

      // held start, one pulse, 256 bursts: counter wraps, one idle cycle between
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst         = 1'b0;
      bus.iPULSES = 8'd1;
      bus.iSTART  = 1'b1;
      tick();
      done_n = 0; idle_n = 0;
      for (int c = 0; c < 6000 && done_n < 256; c++) begin
         if (!bus.oBUSY) idle_n = idle_n + 1;
         if (bus.oDONE) begin
            done_n = done_n + 1;
            if (done_n == 256) bus.iSTART = 1'b0;
         end
         if (done_n < 256) tick();
      end
      bus.iSTART = 1'b0;
      check("wrap_dones", done_n, 256);
      check("wrap_idle_cycles", idle_n, 256);
      check("wrap_cnt", int'(bus.oBURST_CNT), 0);
      tick();
      check("wrap_stop_busy", int'(bus.oBUSY), 0);

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         bus.iSTART  = ($urandom_range(3) == 0);
         bus.iABORT  = ($urandom_range(63) == 0);
         bus.iPULSES = 8'($urandom_range(3));
         tick();
      end
      bus.iSTART = 1'b0;
      bus.iABORT = 1'b0;
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ctu_burst_gen.md
CTU_BURST_GEN -- requirements
Module: ctu_burst_gen

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 500, giving iCLK_40 cycles per transmit half-cycle (40 MHz / 500 / 2 = 40 kHz).
REQ-002 SHALL have parameter BLANK_CYCLES, default 40000, giving iCLK_40 cycles of receiver blanking after a burst (1 ms).
REQ-003 SHALL have parameter CNT_W, default 16, giving the width of the internal half-period and blank counters.
REQ-004 Port iCLK_40  input  1  40 MHz PLL clock (c0 output of the PLL clock stage); only clock in the block.
REQ-005 Port iRST  input  1  reset, asynchronous, active-high.
REQ-006 Port iSTART  input  1  burst request, level sampled on each rising edge.
REQ-007 Port iABORT  input  1  cancel in-progress burst or blank.
REQ-008 Port iPULSES  input  8  number of transmit pulses per burst, 1..255.
REQ-009 Port oTX  output  1  transducer drive, positive leg.
REQ-010 Port oTX_N  output  1  transducer drive, negative leg.
REQ-011 Port oBUSY  output  1  high in BURST or BLANK.
REQ-012 Port oBLANK  output  1  high in BLANK (echo receiver gate).
REQ-013 Port oDONE  output  1  one-cycle completion strobe.
REQ-014 Port oBURST_CNT  output  8  completed-burst count, for LED display.

Function
REQ-015 SHALL implement states IDLE, BURST, BLANK; all outputs registered.
REQ-016 IDLE: iSTART=1 and iPULSES!=0 and iABORT=0 -> BURST on that edge; iPULSES latched into pulse counter on the same edge.
REQ-017 iSTART with iPULSES=0 SHALL be ignored (stay IDLE, no oDONE, no count change).
REQ-018 iSTART in BURST or BLANK SHALL be ignored; no queuing.
REQ-019 BURST: oTX=1 for HALF_PERIOD cycles starting the cycle after acceptance, then 0 for HALF_PERIOD cycles; repeat for latched pulse count.
REQ-020 BURST: oTX_N SHALL equal NOT oTX every cycle; no cycle with both legs high.
REQ-021 BURST -> BLANK at the edge ending the last low half-cycle; burst duration exactly 2*HALF_PERIOD*N cycles.
REQ-022 IDLE and BLANK: oTX=0 and oTX_N=0 (driver off).
REQ-023 BLANK: oBLANK=1 for exactly BLANK_CYCLES cycles, then -> IDLE.
REQ-024 BLANK -> IDLE transition SHALL assert oDONE for one cycle and increment oBURST_CNT in that same cycle.
REQ-025 oBURST_CNT SHALL wrap 255 -> 0.
REQ-026 iABORT=1 in BURST or BLANK SHALL force IDLE on that edge: oTX, oTX_N, oBUSY, oBLANK low next cycle; no oDONE; oBURST_CNT unchanged.
REQ-027 iABORT and iSTART both high in IDLE: abort wins, start ignored.
REQ-028 iSTART held high continuously SHALL retrigger in the first IDLE cycle after oDONE (one idle cycle between bursts).
REQ-029 Changes on iPULSES during BURST SHALL not affect the current burst.

Reset
REQ-030 iRST=1 SHALL asynchronously force IDLE, clear all counters, oTX=oTX_N=oBUSY=oBLANK=oDONE=0, oBURST_CNT=0.
REQ-031 Reset asserted mid-BURST or mid-BLANK SHALL take effect immediately, without waiting for a clock edge, and SHALL not produce oDONE.
REQ-032 First iSTART accepted on the first rising edge after iRST deasserts.

Verification (HALF_PERIOD=4, BLANK_CYCLES=10)
REQ-033 Assert iRST mid-burst -> all outputs 0 immediately, oBURST_CNT=0.
REQ-034 iPULSES=3, iSTART pulse at edge E0 -> oTX high E0-E4, E8-E12, E16-E20; BLANK E24-E34; oDONE=1 for one cycle after E34; oBURST_CNT=1.
REQ-035 iPULSES=0 with iSTART -> oBUSY stays 0, oBURST_CNT unchanged.
REQ-036 iABORT at E10 of a 3-pulse burst -> oTX=oTX_N=oBUSY=0 after E10, no oDONE, oBURST_CNT unchanged.
REQ-037 iSTART held high with iPULSES=1 for 256 bursts -> oBURST_CNT wraps to 0; one idle cycle between bursts.
REQ-038 All scenarios: assert oTX AND oTX_N never 1, and oTX_N equals NOT oTX whenever oBUSY=1 and oBLANK=0.
